// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS multicycle control path: opcodes, FSM states,
// ALU-control op/branch codes and datapath mux selects.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_e;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_BR    = 4'b0001;
  localparam logic [3:0] ALU_BGEZ  = 4'b1001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_RTYPE = 4'b0110;

  localparam logic [2:0] BC_NONE = 3'b000;
  localparam logic [2:0] BC_BLTZ = 3'b001;
  localparam logic [2:0] BC_BEQ  = 3'b100;
  localparam logic [2:0] BC_BNE  = 3'b101;
  localparam logic [2:0] BC_BLEZ = 3'b110;
  localparam logic [2:0] BC_BGTZ = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  function automatic state_e decode_dispatch(input logic [5:0] op);
    case (op)
      OP_RTYPE:                                   return S_REXEC;
      OP_LW, OP_SW:                               return S_MEMADR;
      OP_ADDI, OP_ANDI, OP_ORI:                   return S_IEXEC;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: return S_BRANCH;
      OP_J:                                       return S_JUMP;
      default:                                    return S_TRAP;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts cycles spent stalled on mem_ready and flags a timeout when the
// limit is reached with the memory still not ready.
module mips_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic waiting_i,
  input  logic mem_ready_i,
  output logic timeout_o
);
  localparam int            CW    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          hold;

  // A ready on the limit cycle wins over the timeout.
  assign timeout_o = (MEM_TIMEOUT != 0) && waiting_i && !mem_ready_i && (cnt_q == LIMIT);
  assign hold      = waiting_i && !mem_ready_i && !timeout_o;

  // Any cycle that is not a continued stall leaves the counter at zero,
  // so every fresh entry into a waiting state starts from a clean count.
  always_comb begin
    cnt_d = '0;
    if (hold) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: sequences each instruction through its states
// and decodes the datapath enables, ALU op and branch condition from the state.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       rt0,
  input  logic       mem_ready,
  output logic       memread,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic [1:0] pcsource,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluop,
  output logic [2:0] c,
  output logic       regdst,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       illegal_op,
  output logic       bus_error,
  output logic [3:0] state_o
);
  state_e     state_q, state_d;
  logic [5:0] op_q;
  logic       rt0_q;
  logic       waiting;
  logic       timeout;

  assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign state_o = state_q;

  mips_mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i      (clk),
    .rst_i      (reset),
    .waiting_i  (waiting),
    .mem_ready_i(mem_ready),
    .timeout_o  (timeout)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: state_d = decode_dispatch(opcode);
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_REXEC:  state_d = S_RWB;
      S_IEXEC:  state_d = S_IWB;
      default:  state_d = S_FETCH;
    endcase
    if (timeout) state_d = S_FETCH;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      rt0_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        op_q  <= opcode;
        rt0_q <= rt0;
      end
    end
  end

  always_comb begin
    memread     = 1'b0;
    memwrite    = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    pcsource    = PCS_ALU;
    alusrca     = 1'b0;
    alusrcb     = SRCB_B;
    aluop       = ALU_ADD;
    c           = BC_NONE;
    regdst      = 1'b0;
    regwrite    = 1'b0;
    memtoreg    = 1'b0;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = mem_ready;
        pcwrite = mem_ready;
      end
      S_DECODE: alusrcb = SRCB_IMMSH;
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_REXEC: begin
        alusrca = 1'b1;
        aluop   = ALU_RTYPE;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op_q)
          OP_ANDI: aluop = ALU_AND;
          OP_ORI:  aluop = ALU_OR;
          default: aluop = ALU_ADD;
        endcase
      end
      S_IWB: regwrite = 1'b1;
      S_BRANCH: begin
        alusrca     = 1'b1;
        pcwritecond = 1'b1;
        pcsource    = PCS_ALUOUT;
        aluop       = ALU_BR;
        case (op_q)
          OP_BEQ:  c = BC_BEQ;
          OP_BNE:  c = BC_BNE;
          OP_BLEZ: c = BC_BLEZ;
          OP_BGTZ: c = BC_BGTZ;
          default: begin
            // Only REGIMM reaches here: rt0 picks bgez over bltz.
            if (rt0_q) aluop = ALU_BGEZ;
            else       c     = BC_BLTZ;
          end
        endcase
      end
      S_JUMP: begin
        pcwrite  = 1'b1;
        pcsource = PCS_JUMP;
      end
      S_TRAP:  illegal_op = 1'b1;
      default: ;
    endcase
    bus_error = timeout;
    // No architectural write may escape while in reset or on a timed-out access.
    if (reset || timeout) begin
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      regwrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Lockstep bench: each instruction is expanded into a list of phases from its
// opcode, and the expected control word of every cycle is built from that list.
module tb_mips_mc_control;
  import mips_pkg::*;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       rt0;
  logic       mem_ready;
  logic       memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
  logic [1:0] pcsource;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluop;
  logic [2:0] c;
  logic       regdst, regwrite, memtoreg, illegal_op, bus_error;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  mips_mc_control #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .rt0(rt0), .mem_ready(mem_ready),
    .memread(memread), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .pcsource(pcsource),
    .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop), .c(c),
    .regdst(regdst), .regwrite(regwrite), .memtoreg(memtoreg),
    .illegal_op(illegal_op), .bus_error(bus_error), .state_o(state_o)
  );

  typedef struct packed {
    logic       memread, memwrite, iord, irwrite, pcwrite, pcwritecond;
    logic [1:0] pcsource;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic [2:0] c;
    logic       regdst, regwrite, memtoreg, illegal_op, bus_error;
    logic [3:0] state;
  } ctl_t;

  typedef enum int {
    K_FETCH, K_DECODE, K_ADDR, K_RD, K_LWB, K_WR, K_RX, K_RWB, K_IX, K_IWB, K_BR, K_J, K_TRAP
  } kind_e;

  ctl_t obs;
  assign obs = {memread, memwrite, iord, irwrite, pcwrite, pcwritecond, pcsource, alusrca,
                alusrcb, aluop, c, regdst, regwrite, memtoreg, illegal_op, bus_error, state_o};

  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] cur_op;
  logic       cur_rt0;

  function automatic ctl_t exp_out(kind_e k, logic [5:0] op, logic r0, logic mr, logic to);
    ctl_t e = '0;
    case (k)
      K_FETCH:  begin e.memread = 1; e.alusrcb = 2'b01; e.irwrite = mr; e.pcwrite = mr; e.state = S_FETCH; end
      K_DECODE: begin e.alusrcb = 2'b11; e.state = S_DECODE; end
      K_ADDR:   begin e.alusrca = 1; e.alusrcb = 2'b10; e.state = S_MEMADR; end
      K_RD:     begin e.memread = 1; e.iord = 1; e.state = S_MEMRD; end
      K_LWB:    begin e.regwrite = 1; e.memtoreg = 1; e.state = S_MEMWB; end
      K_WR:     begin e.memwrite = 1; e.iord = 1; e.state = S_MEMWR; end
      K_RX:     begin e.alusrca = 1; e.aluop = 4'b0110; e.state = S_REXEC; end
      K_RWB:    begin e.regwrite = 1; e.regdst = 1; e.state = S_RWB; end
      K_IX: begin
        e.alusrca = 1; e.alusrcb = 2'b10; e.state = S_IEXEC;
        if (op == 6'b001100)      e.aluop = 4'b0010;
        else if (op == 6'b001101) e.aluop = 4'b0011;
      end
      K_IWB:    begin e.regwrite = 1; e.state = S_IWB; end
      K_BR: begin
        e.alusrca = 1; e.pcwritecond = 1; e.pcsource = 2'b01; e.state = S_BRANCH;
        case (op)
          6'b000100: {e.aluop, e.c} = 7'b0001_100;
          6'b000101: {e.aluop, e.c} = 7'b0001_101;
          6'b000110: {e.aluop, e.c} = 7'b0001_110;
          6'b000111: {e.aluop, e.c} = 7'b0001_111;
          default:   {e.aluop, e.c} = r0 ? 7'b1001_000 : 7'b0001_001;
        endcase
      end
      K_J:      begin e.pcwrite = 1; e.pcsource = 2'b10; e.state = S_JUMP; end
      default:  begin e.illegal_op = 1; e.state = S_TRAP; end
    endcase
    if (to) begin
      e.bus_error = 1; e.memwrite = 0; e.regwrite = 0; e.pcwrite = 0; e.pcwritecond = 0; e.irwrite = 0;
    end
    return e;
  endfunction

  task automatic chk(string tag, ctl_t e);
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h required %h", tag, obs, e);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check mid-cycle, advance.
  task automatic step(string tag, kind_e k, logic mr, logic to);
    mem_ready = mr;
    if (k == K_DECODE) begin
      opcode = cur_op;
      rt0    = cur_rt0;
    end else begin
      opcode = 6'($urandom);
      rt0    = 1'($urandom);
    end
    #2;
    chk($sformatf("%s op=%b lo/to=%0b%0b", k.name(), cur_op, mr, to),
        exp_out(k, cur_op, cur_rt0, mr, to));
    @(negedge clk);
  endtask

  // Memory phase: mem_ready low for lo cycles, then high; ok=0 if aborted.
  task automatic wait_phase(kind_e k, int lo, output bit ok);
    int   cnt;
    logic mr, to;
    cnt = 0;
    ok  = 0;
    for (int i = 0; i <= lo; i++) begin
      mr = (i >= lo);
      to = (cnt == TO) && !mr;
      step("wait", k, mr, to);
      if (mr) begin
        ok = 1;
        return;
      end
      if (to) begin
        if (k != K_FETCH) return;
        cnt = 0;
      end else begin
        cnt++;
      end
    end
  endtask

  task automatic run_instr(logic [5:0] op, logic r0, int f_lo, int m_lo);
    kind_e plan[$];
    bit    ok;
    cur_op  = op;
    cur_rt0 = r0;
    wait_phase(K_FETCH, f_lo, ok);
    if (!ok) return;
    step("decode", K_DECODE, 1'($urandom), 1'b0);
    case (op)
      6'b000000: begin plan.push_back(K_RX); plan.push_back(K_RWB); end
      6'b100011: begin plan.push_back(K_ADDR); plan.push_back(K_RD); plan.push_back(K_LWB); end
      6'b101011: begin plan.push_back(K_ADDR); plan.push_back(K_WR); end
      6'b001000, 6'b001100, 6'b001101: begin plan.push_back(K_IX); plan.push_back(K_IWB); end
      6'b000100, 6'b000101, 6'b000110, 6'b000111, 6'b000001: plan.push_back(K_BR);
      6'b000010: plan.push_back(K_J);
      default:   plan.push_back(K_TRAP);
    endcase
    foreach (plan[i]) begin
      if (plan[i] == K_RD || plan[i] == K_WR) begin
        wait_phase(plan[i], m_lo, ok);
        if (!ok) return;
      end else begin
        step("exec", plan[i], 1'($urandom), 1'b0);
      end
    end
  endtask

  function automatic logic [5:0] pick_op(int idx);
    case (idx)
      0: return 6'b000000;  1: return 6'b100011;  2: return 6'b101011;
      3: return 6'b001000;  4: return 6'b001100;  5: return 6'b001101;
      6: return 6'b000100;  7: return 6'b000101;  8: return 6'b000110;
      9: return 6'b000111; 10: return 6'b000001; 11: return 6'b000010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic int pick_lo();
    int r = $urandom_range(0, 9);
    return (r < 6) ? 0 : $urandom_range(1, 6);
  endfunction

  initial begin
    bit ok;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b101011;
    rt0       = 1'b0;
    cur_op    = 6'b000000;
    cur_rt0   = 1'b0;
    @(negedge clk);
    #2 chk("reset_fetch", exp_out(K_FETCH, 6'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    #2 chk("reset_held", exp_out(K_FETCH, 6'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;

    run_instr(6'b000000, 1'b0, 0, 0);        // R-type, 4 cycles
    run_instr(6'b100011, 1'b0, 0, 3);        // lw stalled 3 cycles in MEMRD
    run_instr(6'b000100, 1'b0, 0, 0);        // branch sweep
    run_instr(6'b000101, 1'b0, 0, 0);
    run_instr(6'b000110, 1'b0, 0, 0);
    run_instr(6'b000111, 1'b0, 0, 0);
    run_instr(6'b000001, 1'b0, 0, 0);
    run_instr(6'b000001, 1'b1, 0, 0);
    run_instr(6'b001101, 1'b0, 0, 0);        // ori then andi, addi
    run_instr(6'b001100, 1'b1, 0, 0);
    run_instr(6'b001000, 1'b0, 0, 0);
    run_instr(6'b101011, 1'b0, 0, 10);       // sw timeout
    run_instr(6'b111111, 1'b0, 0, 0);        // illegal opcode
    run_instr(6'b000010, 1'b0, 0, 0);        // jump
    run_instr(6'b001000, 1'b0, 6, 0);        // fetch timeout then success
    run_instr(6'b100011, 1'b0, 0, 7);        // lw timeout in MEMRD
    run_instr(6'b101011, 1'b0, 0, TO);       // ready exactly on the limit
    run_instr(6'b100011, 1'b1, 0, TO);

    // Reset asserted in the middle of a stalled store.
    cur_op  = 6'b101011;
    cur_rt0 = 1'b0;
    wait_phase(K_FETCH, 0, ok);
    step("decode", K_DECODE, 1'b1, 1'b0);
    step("addr", K_ADDR, 1'b0, 1'b0);
    step("wr", K_WR, 1'b0, 1'b0);
    step("wr", K_WR, 1'b0, 1'b0);
    #1 reset = 1'b1;
    #1 chk("reset_in_memwr", exp_out(K_FETCH, 6'b0, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    reset = 1'b0;
    run_instr(6'b000000, 1'b0, 0, 0);

    for (int n = 0; n < 80; n++) begin
      run_instr(pick_op($urandom_range(0, 13)), 1'($urandom), pick_lo(), pick_lo());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
